// File: rtl/wb_cmd_master_pkg.sv
// Shared types and defaults for the Wishbone command master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_cmd_master_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/wb_ack_timeout.sv
// Ack-wait counter: loadable up-counter with clear/enable; expired marks the last allowed edge.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts only while en is high.
module wb_ack_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              load,
    input  logic [$clog2(TIMEOUT_CYCLES)-1:0] load_val,
    input  logic                              en,
    output logic                              expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High while the count shows TIMEOUT_CYCLES-1 elapsed edges, so the next edge is the last.
    assign expired = (cnt == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: one bus cycle per command, ack timeout; retry via WB_CMD_MASTER_RETRY_EN.
// Latency: cmd accept to rsp_valid is 2 edges with a zero-wait slave, plus slave wait states.
// Backpressure: cmd_ready low from accept until the response handshake completes.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_W-1:0]    cmd_adr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    wb_adr,
    output logic [DATA_W-1:0]    wb_dat_mosi,
    input  logic [DATA_W-1:0]    wb_dat_miso,
    output logic                 wb_we,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    input  logic                 wb_ack,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_param_check
        $error("wb_cmd_master: TIMEOUT_CYCLES must be >= 2 and MAX_RETRY >= 0");
    end

    state_e                 state_q, state_d;
    logic                   cmd_ready_d, rsp_valid_d, rsp_err_d, wb_we_d, wb_cyc_d, wb_stb_d;
    logic [DATA_W-1:0]      rsp_rdata_d, wb_dat_mosi_d;
    logic [ADDR_W-1:0]      wb_adr_d;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic                   tmo_expired;

`ifdef WB_CMD_MASTER_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retry_q, retry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry_q <= '0;
        else        retry_q <= retry_d;
    end
`endif

    // Counter runs only in BUS; any other state (including GAP) holds it at zero.
    wb_ack_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q != ST_BUS),
        .load     (1'b0),
        .load_val ('0),
        .en       (state_q == ST_BUS),
        .expired  (tmo_expired)
    );

    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        wb_adr_d      = wb_adr;
        wb_dat_mosi_d = wb_dat_mosi;
        wb_we_d       = wb_we;
        wb_cyc_d      = wb_cyc;
        wb_stb_d      = wb_stb;
        err_cnt_d     = err_cnt;
`ifdef WB_CMD_MASTER_RETRY_EN
        retry_d       = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wb_adr_d      = cmd_adr;
                    wb_dat_mosi_d = cmd_wdata;
                    wb_we_d       = cmd_we;
                    wb_cyc_d      = 1'b1;
                    wb_stb_d      = 1'b1;
                    state_d       = ST_BUS;
`ifdef WB_CMD_MASTER_RETRY_EN
                    retry_d       = '0;
`endif
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the final timeout edge still succeeds.
                if (wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                    rsp_rdata_d = wb_we ? '0 : wb_dat_miso;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (tmo_expired) begin
                    wb_cyc_d = 1'b0;
                    wb_stb_d = 1'b0;
`ifdef WB_CMD_MASTER_RETRY_EN
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
`else
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`endif
                end
            end
            ST_GAP: begin
                wb_cyc_d = 1'b1;
                wb_stb_d = 1'b1;
                state_d  = ST_BUS;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (rsp_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            wb_adr      <= '0;
            wb_dat_mosi <= '0;
            wb_we       <= 1'b0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            wb_adr      <= wb_adr_d;
            wb_dat_mosi <= wb_dat_mosi_d;
            wb_we       <= wb_we_d;
            wb_cyc      <= wb_cyc_d;
            wb_stb      <= wb_stb_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule
